// File: rtl/sw_debounce_pulse.sv
// Switch/button conditioner: two-flop synchroniser, per-channel debounce FSM,
// registered level plus single-cycle rise/fall pulses.
module sw_debounce_pulse #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  typedef enum logic [1:0] {
    StLo,
    StPendHi,
    StHi,
    StPendLo
  } state_e;

  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               Immediate = (DEBOUNCE_CYCLES == 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_d, rs_d, fl_d;
    logic             s;

    assign s = sync2_q[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = level_q[i];
      rs_d    = 1'b0;
      fl_d    = 1'b0;
      unique case (state_q)
        StLo: begin
          if (s) begin
            if (Immediate) begin
              state_d = StHi;
              lvl_d   = 1'b1;
              rs_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StPendHi;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        StPendHi: begin
          if (!s) begin
            state_d = StLo;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StHi;
            lvl_d   = 1'b1;
            rs_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StHi: begin
          if (!s) begin
            if (Immediate) begin
              state_d = StLo;
              lvl_d   = 1'b0;
              fl_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StPendLo;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        StPendLo: begin
          if (s) begin
            state_d = StHi;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StLo;
            lvl_d   = 1'b0;
            fl_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StLo;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StLo;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_d[i] = lvl_d;
    assign rise_d[i]  = rs_d;
    assign fall_d[i]  = fl_d;
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule
